// File: rtl/obi_byteram_pkg.sv
// Shared types and constants for the OBI front-end of the byte-addressed test RAM.
package obi_byteram_pkg;

  typedef enum logic [1:0] {
    GNT_ALWAYS = 2'd0,
    GNT_FIXED  = 2'd1,
    GNT_RANDOM = 2'd2
  } gnt_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReady
  } gnt_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: bits 0,2,3,5 are taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        is_read;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/obi_gnt_gen.sv
// Grant throttle: always-on, fixed stall after req, or LFSR-driven pseudo-random.
module obi_gnt_gen
  import obi_byteram_pkg::*;
#(
  parameter int unsigned GNT_MODE  = 0,
  parameter int unsigned GNT_DELAY = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_xfer,
  output logic o_gen_ok
);

  localparam gnt_mode_e  Mode  = gnt_mode_e'(GNT_MODE[1:0]);
  localparam logic [3:0] Delay = GNT_DELAY[3:0];

  gnt_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_lfsr;
  logic        w_fb;
  logic [3:0]  w_cnt_inc;

  assign w_fb      = ^(r_lfsr & LFSR_TAPS);
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
      if (!i_req) begin
        r_state <= StIdle;
        r_cnt   <= 4'd0;
      end else if (i_xfer) begin
        // Each new request pays the full stall again.
        r_state <= (Delay == 4'd0) ? StReady : StWait;
        r_cnt   <= 4'd0;
      end else if (r_cnt != Delay) begin
        r_cnt   <= w_cnt_inc;
        r_state <= (w_cnt_inc == Delay) ? StReady : StWait;
      end
    end
  end

  always_comb begin
    case (Mode)
      GNT_FIXED:  o_gen_ok = (Delay == 4'd0) || (r_state == StReady);
      GNT_RANDOM: o_gen_ok = r_lfsr[0];
      default:    o_gen_ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/obi_byteram_if.sv
// OBI slave front-end for a single-port byte RAM: throttled grant, in-order responses,
// configurable response latency and error responses outside the RAM window.
module obi_byteram_if
  import obi_byteram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned GNT_MODE        = 0,
  parameter int unsigned GNT_DELAY       = 2,
  parameter int unsigned RVALID_DELAY    = 0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  obi_req_i,
  output logic                  obi_gnt_o,
  input  logic [31:0]           obi_addr_i,
  input  logic                  obi_we_i,
  input  logic [3:0]            obi_be_i,
  input  logic [31:0]           obi_wdata_i,
  output logic                  obi_rvalid_o,
  output logic [31:0]           obi_rdata_o,
  output logic                  obi_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned     Depth  = RVALID_DELAY + 1;
  localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] One    = CntW'(1);

  logic            w_gen_ok;
  logic            w_in_range;
  logic            w_slot_free;
  logic            w_xfer;
  logic            w_unused_addr;
  logic [CntW-1:0] r_outstanding;
  resp_t           r_pipe [Depth];
  resp_t           w_head;
  resp_t           w_tail;

  obi_gnt_gen #(
    .GNT_MODE  (GNT_MODE),
    .GNT_DELAY (GNT_DELAY)
  ) u_gnt_gen (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_req    (obi_req_i),
    .i_xfer   (w_xfer),
    .o_gen_ok (w_gen_ok)
  );

  assign w_in_range    = (obi_addr_i[31:ADDR_WIDTH] == '0);
  // A retiring response frees its slot in the same cycle.
  assign w_slot_free   = (r_outstanding < MaxOut) | obi_rvalid_o;
  assign obi_gnt_o     = obi_req_i & w_gen_ok & w_slot_free & ~rst_i;
  assign w_xfer        = obi_gnt_o;
  assign w_unused_addr = ^obi_addr_i[1:0];

  // Reset forces every output low even while the core keeps driving the bus.
  assign ram_en_o    = w_xfer & w_in_range;
  assign ram_addr_o  = rst_i ? '0 : {obi_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign ram_we_o    = ram_en_o & obi_we_i;
  assign ram_be_o    = ram_en_o ? obi_be_i : 4'b0000;
  assign ram_wdata_o = ram_en_o ? obi_wdata_i : 32'd0;

  // RAM data is only valid the cycle after the access, so stage 0 picks it up directly.
  always_comb begin
    w_head       = r_pipe[0];
    w_head.rdata = (r_pipe[0].valid & r_pipe[0].is_read & ~r_pipe[0].err) ? ram_rdata_i : 32'd0;
    w_tail       = (Depth == 1) ? w_head : r_pipe[Depth-1];
  end

  assign obi_rvalid_o = w_tail.valid;
  assign obi_err_o    = w_tail.err;
  assign obi_rdata_o  = w_tail.rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) r_pipe[i] <= '0;
      r_outstanding <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_xfer, err: w_xfer & ~w_in_range, is_read: w_xfer & ~obi_we_i,
                     rdata: 32'd0};
      for (int unsigned i = 1; i < Depth; i++) r_pipe[i] <= (i == 1) ? w_head : r_pipe[i-1];
      if (w_xfer & ~obi_rvalid_o) r_outstanding <= r_outstanding + One;
      else if (~w_xfer & obi_rvalid_o) r_outstanding <= r_outstanding - One;
    end
  end

endmodule

// File: tb/tb_obi_byteram_if.sv
// Directed bench for obi_byteram_if: four configurations sharing one behavioural byte RAM.
module tb_obi_byteram_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt [4];
  logic        rvalid [4];
  logic [31:0] rdata [4];
  logic        err [4];
  logic        ram_en [4];
  logic [7:0]  ram_addr [4];
  logic [31:0] ram_wdata [4];
  logic        ram_we [4];
  logic [3:0]  ram_be [4];
  logic [31:0] ram_rd [4];

  logic [31:0] mem [64];
  logic [15:0] lf;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  obi_byteram_if #(.ADDR_WIDTH(8), .GNT_MODE(0), .GNT_DELAY(0), .RVALID_DELAY(0),
                   .MAX_OUTSTANDING(1)) u0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid[0]),
    .obi_rdata_o(rdata[0]), .obi_err_o(err[0]), .ram_en_o(ram_en[0]), .ram_addr_o(ram_addr[0]),
    .ram_wdata_o(ram_wdata[0]), .ram_we_o(ram_we[0]), .ram_be_o(ram_be[0]),
    .ram_rdata_i(ram_rd[0]));

  obi_byteram_if #(.ADDR_WIDTH(8), .GNT_MODE(1), .GNT_DELAY(3), .RVALID_DELAY(0),
                   .MAX_OUTSTANDING(1)) u1 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid[1]),
    .obi_rdata_o(rdata[1]), .obi_err_o(err[1]), .ram_en_o(ram_en[1]), .ram_addr_o(ram_addr[1]),
    .ram_wdata_o(ram_wdata[1]), .ram_we_o(ram_we[1]), .ram_be_o(ram_be[1]),
    .ram_rdata_i(ram_rd[1]));

  obi_byteram_if #(.ADDR_WIDTH(8), .GNT_MODE(0), .GNT_DELAY(0), .RVALID_DELAY(3),
                   .MAX_OUTSTANDING(2)) u2 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[2]), .obi_gnt_o(gnt[2]), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid[2]),
    .obi_rdata_o(rdata[2]), .obi_err_o(err[2]), .ram_en_o(ram_en[2]), .ram_addr_o(ram_addr[2]),
    .ram_wdata_o(ram_wdata[2]), .ram_we_o(ram_we[2]), .ram_be_o(ram_be[2]),
    .ram_rdata_i(ram_rd[2]));

  obi_byteram_if #(.ADDR_WIDTH(8), .GNT_MODE(2), .GNT_DELAY(0), .RVALID_DELAY(0),
                   .MAX_OUTSTANDING(1)) u3 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req[3]), .obi_gnt_o(gnt[3]), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid[3]),
    .obi_rdata_o(rdata[3]), .obi_err_o(err[3]), .ram_en_o(ram_en[3]), .ram_addr_o(ram_addr[3]),
    .ram_wdata_o(ram_wdata[3]), .ram_we_o(ram_we[3]), .ram_be_o(ram_be[3]),
    .ram_rdata_i(ram_rd[3]));

  // Registered-read RAM; the old word is returned on writes too, so masking is observable.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_en[k]) begin
        ram_rd[k] <= mem[ram_addr[k][7:2]];
        if (ram_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[k][b]) mem[ram_addr[k][7:2]][8*b +: 8] = ram_wdata[k][8*b +: 8];
        end
      end
    end
  end

  // Reference grant LFSR (x^16 + x^14 + x^13 + x^11 + 1).
  always @(posedge clk or posedge rst) begin
    if (rst) lf <= 16'hACE1;
    else     lf <= (lf >> 1) | (16'(lf[0] ^ lf[2] ^ lf[3] ^ lf[5]) << 15);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag, input int k);
    chk1({tag, " gnt"}, gnt[k], 1'b0);
    chk1({tag, " rvalid"}, rvalid[k], 1'b0);
    chk({tag, " rdata"}, rdata[k], 32'd0);
    chk1({tag, " err"}, err[k], 1'b0);
    chk1({tag, " ram_en"}, ram_en[k], 1'b0);
    chk({tag, " ram_addr"}, 32'(ram_addr[k]), 32'd0);
    chk1({tag, " ram_we"}, ram_we[k], 1'b0);
    chk({tag, " ram_be"}, 32'(ram_be[k]), 32'd0);
    chk({tag, " ram_wdata"}, ram_wdata[k], 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        en;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  initial begin : main
    vec_t        vecs [10];
    logic        eg;
    logic        g;
    logic        pend;
    logic [31:0] pend_data;
    logic [31:0] a;
    int          n_sent;
    int          n_rcv;
    int          n_xfer;

    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'h3, 32'h1122_3344, 1'b1, 8'h20, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b1, 8'h20, 32'hAABB_3344, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_00FC, 4'hF, 32'h0,         1'b1, 8'hFC, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         1'b0, 8'h00, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 32'h0000_0400, 4'hF, 32'h0,         1'b0, 8'h00, 32'h0,         1'b1};
    vecs[7] = '{1'b1, 32'h8000_0010, 4'hF, 32'h1234_5678, 1'b0, 8'h10, 32'h0,         1'b1};
    vecs[8] = '{1'b1, 32'h0000_00FC, 4'hC, 32'h0102_0304, 1'b1, 8'hFC, 32'h0,         1'b0};
    vecs[9] = '{1'b0, 32'h0000_00FE, 4'hF, 32'h0,         1'b1, 8'hFC, 32'h0102_F00D, 1'b0};

    for (int i = 0; i < 64; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
    mem[4]  = 32'hDEAD_BEEF;
    mem[8]  = 32'hAABB_CCDD;
    mem[63] = 32'hCAFE_F00D;

    // Reset with an active-looking bus: every output must still read 0.
    req = 4'b0101; addr = 32'h0000_0010; we = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF;
    #1 rst = 1'b1;
    #1;
    chk_all_zero("reset u0", 0);
    chk_all_zero("reset u2", 2);
    req = 4'b0000; we = 1'b0; be = 4'hF; wdata = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single transfers through the mode-0, zero-delay instance.
    for (int i = 0; i < 10; i++) begin
      req[0] = 1'b1; we = vecs[i].we; addr = vecs[i].addr; be = vecs[i].be;
      wdata = vecs[i].wdata;
      @(negedge clk);
      chk1($sformatf("vec%0d gnt", i), gnt[0], 1'b1);
      chk1($sformatf("vec%0d ram_en", i), ram_en[0], vecs[i].en);
      chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr[0]), 32'(vecs[i].raddr));
      chk1($sformatf("vec%0d ram_we", i), ram_we[0], vecs[i].en & vecs[i].we);
      chk($sformatf("vec%0d ram_be", i), 32'(ram_be[0]), vecs[i].en ? 32'(vecs[i].be) : 32'd0);
      chk($sformatf("vec%0d ram_wdata", i), ram_wdata[0], vecs[i].en ? vecs[i].wdata : 32'd0);
      chk1($sformatf("vec%0d rvalid early", i), rvalid[0], 1'b0);
      next_cycle();
      req[0] = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d rvalid", i), rvalid[0], 1'b1);
      chk($sformatf("vec%0d rdata", i), rdata[0], vecs[i].rdata);
      chk1($sformatf("vec%0d err", i), err[0], vecs[i].err);
      next_cycle();
    end

    // Fixed delay 3: address/we wander while stalled, grants at cycles 3 and 7.
    we = 1'b0; be = 4'hF; wdata = 32'd0;
    for (int c = 0; c < 8; c++) begin
      eg = (c == 3) || (c == 7);
      req[1] = 1'b1; we = ~eg; addr = 32'h40 + 32'(4 * c);
      @(negedge clk);
      chk1($sformatf("m1 c%0d gnt", c), gnt[1], eg);
      chk1($sformatf("m1 c%0d ram_en", c), ram_en[1], eg);
      chk1($sformatf("m1 c%0d ram_we", c), ram_we[1], 1'b0);
      chk1($sformatf("m1 c%0d rvalid", c), rvalid[1], c == 4);
      next_cycle();
    end
    req[1] = 1'b0; we = 1'b0;
    @(negedge clk);
    chk1("m1 second rvalid", rvalid[1], 1'b1);
    chk("m1 second rdata", rdata[1], 32'h5A5A_0000 + 32'(16 + 7));
    next_cycle();

    // Early drop restarts the stall count.
    for (int c = 0; c < 7; c++) begin
      req[1] = (c != 2); addr = 32'h10;
      @(negedge clk);
      chk1($sformatf("m1 drop c%0d gnt", c), gnt[1], c == 6);
      next_cycle();
    end
    req[1] = 1'b0;
    @(negedge clk);
    chk1("m1 drop rvalid", rvalid[1], 1'b1);
    chk("m1 drop rdata", rdata[1], 32'hDEAD_BEEF);
    next_cycle();

    // Outstanding limit 2 with 3 extra response cycles.
    n_sent = 0; n_rcv = 0;
    for (int c = 0; c < 12; c++) begin
      req[2] = (n_sent < 4); addr = 32'(4 * n_sent); we = 1'b0;
      @(negedge clk);
      g = gnt[2];
      if (c < 6) chk1($sformatf("lim c%0d gnt", c), g, (c < 2) || (c > 3));
      chk1($sformatf("lim c%0d rvalid", c), rvalid[2], c == 4 || c == 5 || c == 8 || c == 9);
      if (rvalid[2]) begin
        chk($sformatf("lim resp%0d rdata", n_rcv), rdata[2], 32'h5A5A_0000 + 32'(n_rcv));
        chk1($sformatf("lim resp%0d err", n_rcv), err[2], 1'b0);
        n_rcv++;
      end
      next_cycle();
      if (g) n_sent++;
    end
    chk("lim responses", 32'(n_rcv), 32'd4);

    // Pseudo-random grant against the reference LFSR.
    pend = 1'b0; pend_data = 32'd0; n_xfer = 0;
    for (int c = 0; c < 2000 && n_xfer < 100; c++) begin
      req[3] = ($urandom_range(0, 3) != 0);
      a = 32'($urandom_range(0, 63)) * 4;
      addr = a; we = 1'b0;
      @(negedge clk);
      eg = req[3] & lf[0];
      chk1($sformatf("m2 c%0d gnt", c), gnt[3], eg);
      chk1($sformatf("m2 c%0d rvalid", c), rvalid[3], pend);
      if (pend) chk($sformatf("m2 c%0d rdata", c), rdata[3], pend_data);
      next_cycle();
      pend = eg;
      pend_data = mem[a[7:2]];
      if (eg) n_xfer++;
    end
    req[3] = 1'b0;
    chk("m2 transfers", 32'(n_xfer), 32'd100);
    @(negedge clk);
    chk1("m2 last rvalid", rvalid[3], pend);
    if (pend) chk("m2 last rdata", rdata[3], pend_data);
    next_cycle();

    // Reset with two responses in flight.
    req[2] = 1'b1; addr = 32'h0; we = 1'b0;
    @(negedge clk);
    chk1("rst seq gnt0", gnt[2], 1'b1);
    next_cycle();
    addr = 32'h4;
    @(negedge clk);
    chk1("rst seq gnt1", gnt[2], 1'b1);
    next_cycle();
    rst = 1'b1; addr = 32'h8; we = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF;
    #1;
    chk_all_zero("midrst u2", 2);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    req[2] = 1'b0; we = 1'b0; wdata = 32'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk1($sformatf("post-rst c%0d rvalid", c), rvalid[2], 1'b0);
      next_cycle();
    end
    req[2] = 1'b1; addr = 32'h8;
    @(negedge clk);
    chk1("post-rst gnt", gnt[2], 1'b1);
    next_cycle();
    req[2] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk1($sformatf("post-rst resp c%0d rvalid", c), rvalid[2], c == 4);
      if (c == 4) chk("post-rst rdata", rdata[2], 32'h5A5A_0002);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_byteram_if.md
# obi_byteram_if

OBI slave front-end that sits directly upstream of the testbench byte-addressed single-port RAM. It accepts core instruction/data requests (`req`/`gnt`/`rvalid`), drives one RAM access per granted transfer, and returns in-order responses. Grant is throttled by a configurable stall generator, response latency is configurable, and accesses outside the RAM window return an error response.

## Interface
- `ADDR_WIDTH`, 8: RAM byte-address width; the RAM window is `[0, 2**ADDR_WIDTH)`.
- `GNT_MODE`, 0: grant policy. 0 = always, 1 = fixed delay, 2 = pseudo-random.
- `GNT_DELAY`, 2: stall cycles before grant in mode 1 (0–15).
- `RVALID_DELAY`, 0: extra response cycles beyond the RAM's 1-cycle latency (0–7).
- `MAX_OUTSTANDING`, 2: in-flight transfer limit (1 to `RVALID_DELAY`+1).
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `obi_req_i`, in, 1: request.
- `obi_gnt_o`, out, 1: grant.
- `obi_addr_i`, in, 32: byte address.
- `obi_we_i`, in, 1: write enable.
- `obi_be_i`, in, 4: byte enables.
- `obi_wdata_i`, in, 32: write data.
- `obi_rvalid_o`, out, 1: response valid.
- `obi_rdata_o`, out, 32: read data.
- `obi_err_o`, out, 1: response error, qualified by `rvalid`.
- `ram_en_o`, out, 1: RAM access strobe.
- `ram_addr_o`, out, `ADDR_WIDTH`: RAM byte address, word-aligned.
- `ram_wdata_o`, out, 32: RAM write data.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_be_o`, out, 4: RAM byte enables.
- `ram_rdata_i`, in, 32: RAM read data, registered, valid 1 cycle after `en`.

## Operation
- **Transfer:** a transfer occurs when `obi_req_i & obi_gnt_o` are both high at a rising edge.
- **Grant:** `obi_gnt_o = obi_req_i & gen_ok & (outstanding < MAX_OUTSTANDING)`. It is combinational.
- **Grant generator FSM** (states IDLE, WAIT, READY):
  - Mode 0: `gen_ok` is always 1.
  - Mode 1, entry and counting: IDLE → WAIT on `req`. A 4-bit counter counts cycles with `req` high. `gen_ok` rises when `cnt == GNT_DELAY` (READY).
  - Mode 1, after a transfer: the counter clears. The FSM returns to IDLE if `req` is low, otherwise to WAIT.
  - Mode 1, `GNT_DELAY` = 0: behaves as mode 0.
  - Mode 1, early drop: if `req` drops before grant, the FSM returns to IDLE and the counter clears.
  - Mode 2: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle, including idle cycles. `gen_ok = lfsr[0]`.
- **In-range test:** `in_range = (obi_addr_i[31:ADDR_WIDTH] == 0)`.
- **RAM drive:**
  - `ram_en_o = transfer & in_range`.
  - `ram_addr_o = {obi_addr_i[ADDR_WIDTH-1:2], 2'b00}`.
  - `ram_we_o`, `ram_be_o` and `ram_wdata_o` are forwarded from the OBI inputs, gated to 0 when `ram_en_o` = 0.
- **Response pipeline:** a shift line of depth `RVALID_DELAY`+1 carries {valid, err, is_read}.
  - Data is captured from `ram_rdata_i` in the cycle after the transfer.
  - Out-of-range transfers have err=1 and rdata=0.
  - Writes return rdata=0 and err=0.
- **Outstanding counter:** +1 on transfer, −1 on `rvalid`. When both occur in the same cycle the count is unchanged. Responses are strictly in order.

## Timing
- **Reset values:** all outputs are 0. `outstanding` = 0, the FSM is in IDLE, the counter is 0, and the LFSR holds the seed.
- **Latency:** a transfer at edge T produces `obi_rvalid_o` high in cycle T+1+`RVALID_DELAY`, for exactly one cycle per transfer.
- **Back-to-back:** transfers at consecutive edges produce back-to-back `rvalid`.
- **Outstanding limit:** when `outstanding == MAX_OUTSTANDING`, `gnt` = 0. Grant may reassert in the same cycle that `rvalid` retires a slot.
- **Reset mid-operation:** in-flight responses are discarded. No `rvalid` is produced after reset deasserts for pre-reset transfers.
- **Address changes:** address or `we` changes while `req` is high and ungranted do not affect the RAM. `ram_en_o` stays 0 until the grant.
- **Window boundaries:** address `2**ADDR_WIDTH - 4` is in range; address `2**ADDR_WIDTH` is an error.

## Structure
- **Package `obi_byteram_pkg`:**
  - `gnt_mode_e` enum (`GNT_ALWAYS`, `GNT_FIXED`, `GNT_RANDOM`).
  - `gnt_state_e` enum.
  - `LFSR_SEED` and `LFSR_TAPS` constants.
  - `resp_t` struct {valid, err, is_read, rdata}.
- **Sub-module `obi_gnt_gen`:** contains the FSM, the delay counter and the LFSR, and outputs `gen_ok`. The top level holds RAM drive, the response line and the outstanding counter.

## Test plan
- **Mode 0, `RVALID_DELAY`=0:**
  - Stimulus: read at 0x10 with the RAM word at 0x10 = 0xDEADBEEF.
  - Required: `gnt` in the same cycle, `ram_en_o`=1 with `ram_addr_o`=0x10, `rvalid` next cycle with rdata=0xDEADBEEF and err=0.
- **Mode 1, `GNT_DELAY`=3:**
  - Stimulus: `req` held from cycle 0.
  - Required: `gnt` first high in cycle 3. A second back-to-back request is granted 3 cycles after the first transfer.
- **Out-of-range:**
  - Stimulus: read at 0x400 with `ADDR_WIDTH`=8.
  - Required: `ram_en_o` stays 0, `rvalid` with err=1 and rdata=0.
- **Outstanding limit:**
  - Stimulus: `RVALID_DELAY`=3, `MAX_OUTSTANDING`=2, 4 back-to-back reads.
  - Required: `gnt` low after 2 transfers, resuming in the cycle the first `rvalid` fires. 4 in-order responses.
- **Mode 2:**
  - Stimulus: 100 random reads.
  - Required: grant cycles match a reference LFSR seeded with 0xACE1. Every transfer receives exactly one in-order response.
- **Reset mid-operation:**
  - Stimulus: assert `rst_i` with 2 responses in flight.
  - Required: all outputs are 0 immediately, and no stale `rvalid` appears after reset release.
